pdm_cic_decimator: RTL and testbench

PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

---
 rtl/pdm_cic_pkg.sv | 17 +
 rtl/pdm_cic_decimator_if.sv | 15 +
 rtl/cic_integrator_chain.sv | 44 ++++
 rtl/pdm_cic_decimator.sv | 170 +++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_cic_pkg.sv
// rtl/pdm_cic_pkg.sv - shared types, constants and width helper for the PDM CIC decimator
package pdm_cic_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } drain_state_e;

   // Signed level each PDM bit contributes to the first integrator.
   localparam int PDM_LEVEL_HI = 1;
   localparam int PDM_LEVEL_LO = -1;

   function automatic int cic_width(input int order, input int rmax);
      return order * $clog2(rmax) + 2;
   endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// rtl/pdm_cic_decimator_if.sv - decimated sample stream with valid/ready handshake
interface pdm_cic_decimator_if #(
   parameter int CH    = 2,
   parameter int OUT_W = 16
);
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic [CH_W-1:0]         out_ch;

   modport master (output out_valid, out_data, out_ch, input out_ready);
   modport slave  (input out_valid, out_data, out_ch, output out_ready);
endinterface

// File: rtl/cic_integrator_chain.sv
// rtl/cic_integrator_chain.sv - one channel's cascade of ORDER wrap-around integrators
module cic_integrator_chain
   import pdm_cic_pkg::*;
#(
   parameter int ORDER = 3,
   parameter int W     = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         step,
   input  logic         pdm_bit,
   output logic [W-1:0] integ_out
);

   logic [W-1:0] acc_q [ORDER];
   logic [W-1:0] acc_d [ORDER];

   // Each stage accumulates the freshly updated value of the stage before it,
   // so the whole cascade advances by exactly one sample per strobe.
   always_comb begin
      acc_d = acc_q;
      if (step) begin
         acc_d[0] = acc_q[0] + (pdm_bit ? W'(PDM_LEVEL_HI) : W'(PDM_LEVEL_LO));
         for (int i = 1; i < ORDER; i++) begin
            acc_d[i] = acc_q[i] + acc_d[i-1];
         end
      end
      if (clr) begin
         acc_d = '{default: '0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '{default: '0};
      end else begin
         acc_q <= acc_d;
      end
   end

   assign integ_out = acc_q[ORDER-1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - multichannel PDM CIC decimator with shared combs and frame drain FSM
module pdm_cic_decimator
   import pdm_cic_pkg::*;
#(
   parameter int CH    = 2,
   parameter int ORDER = 3,
   parameter int RMAX  = 16,
   parameter int OUT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  pdm_stb,
   input  logic [CH-1:0]         pdm_in,
   input  logic [$clog2(RMAX):0] dec_r,
   pdm_cic_decimator_if.master   out_if,
   output logic                  overrun
);

   localparam int W    = cic_width(ORDER, RMAX);
   localparam int RW   = $clog2(RMAX) + 1;
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

   function automatic logic [RW-1:0] clamp_r(input logic [RW-1:0] r);
      if (r < RW'(2)) return RW'(2);
      if (r > RW'(RMAX)) return RW'(RMAX);
      return r;
   endfunction

   logic [W-1:0] integ_out [CH];

   for (genvar c = 0; c < CH; c++) begin : g_ch
      cic_integrator_chain #(
         .ORDER (ORDER),
         .W     (W)
      ) u_integ (
         .clk       (clk),
         .rst       (rst),
         .clr       (~en),
         .step      (pdm_stb & en),
         .pdm_bit   (pdm_in[c]),
         .integ_out (integ_out[c])
      );
   end

   logic                    en_prev_q, en_prev_d;
   logic [RW-1:0]           r_q, r_d;
   logic [RW-1:0]           phase_q, phase_d;
   logic                    event_q, event_d;
   logic [W-1:0]            comb_dly_q [CH][ORDER];
   logic [W-1:0]            comb_dly_d [CH][ORDER];
   logic signed [OUT_W-1:0] buf_q [CH];
   logic signed [OUT_W-1:0] buf_d [CH];
   drain_state_e            state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic                    overrun_q, overrun_d;

   logic          en_rise;
   logic [RW-1:0] r_cur;
   logic          hs, last_hs, load;
   logic [W-1:0]  comb_s;
   logic [W-1:0]  comb_res [CH];

   always_comb begin
      en_rise   = en & ~en_prev_q;
      r_cur     = en_rise ? clamp_r(dec_r) : r_q;
      en_prev_d = en;
      r_d       = r_cur;
      phase_d   = phase_q;
      event_d   = 1'b0;
      if (pdm_stb) begin
         if (phase_q >= r_cur - RW'(1)) begin
            phase_d = '0;
            event_d = 1'b1;
         end else begin
            phase_d = phase_q + RW'(1);
         end
      end

      // Combs run one cycle after the event so they see the integrators
      // already updated with the frame's last sample.
      comb_dly_d = comb_dly_q;
      comb_res   = '{default: '0};
      comb_s     = '0;
      for (int c = 0; c < CH; c++) begin
         comb_s = integ_out[c];
         for (int j = 0; j < ORDER; j++) begin
            if (event_q) begin
               comb_dly_d[c][j] = comb_s;
            end
            comb_s = comb_s - comb_dly_q[c][j];
         end
         comb_res[c] = comb_s;
      end

      hs      = (state_q == ST_SEND) & out_if.out_ready;
      last_hs = hs & (ch_q == CH_W'(CH - 1));
      load    = event_q & ((state_q == ST_IDLE) | last_hs);

      buf_d = buf_q;
      if (load) begin
         for (int c = 0; c < CH; c++) begin
            buf_d[c] = comb_res[c][W-1 -: OUT_W];
         end
      end

      state_d   = state_q;
      ch_d      = ch_q;
      overrun_d = overrun_q & ~en_rise;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_SEND;
               ch_d    = '0;
            end
         end
         ST_SEND: begin
            if (last_hs) begin
               state_d = load ? ST_SEND : ST_IDLE;
               ch_d    = '0;
            end else if (hs) begin
               ch_d = ch_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (event_q & ~load) begin
         overrun_d = 1'b1;
      end

      if (!en) begin
         phase_d    = '0;
         event_d    = 1'b0;
         comb_dly_d = '{default: '0};
         buf_d      = '{default: '0};
         state_d    = ST_IDLE;
         ch_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_prev_q  <= en;
         r_q        <= clamp_r(dec_r);
         phase_q    <= '0;
         event_q    <= 1'b0;
         comb_dly_q <= '{default: '0};
         buf_q      <= '{default: '0};
         state_q    <= ST_IDLE;
         ch_q       <= '0;
         overrun_q  <= 1'b0;
      end else begin
         en_prev_q  <= en_prev_d;
         r_q        <= r_d;
         phase_q    <= phase_d;
         event_q    <= event_d;
         comb_dly_q <= comb_dly_d;
         buf_q      <= buf_d;
         state_q    <= state_d;
         ch_q       <= ch_d;
         overrun_q  <= overrun_d;
      end
   end

   assign out_if.out_valid = (state_q == ST_SEND);
   assign out_if.out_data  = buf_q[ch_q];
   assign out_if.out_ch    = ch_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - self-checking bench for pdm_cic_decimator
module tb_pdm_cic_decimator;
   import pdm_cic_pkg::*;

   localparam int CH    = 2;
   localparam int ORDER = 3;
   localparam int RMAX  = 8;
   localparam int OUT_W = 11;
   localparam int W     = cic_width(ORDER, RMAX);

   logic          clk = 1'b0;
   logic          rst, en, pdm_stb;
   logic [CH-1:0] pdm_in;
   logic [3:0]    dec_r;
   logic          overrun;

   pdm_cic_decimator_if #(.CH(CH), .OUT_W(OUT_W)) bus ();

   pdm_cic_decimator #(
      .CH(CH), .ORDER(ORDER), .RMAX(RMAX), .OUT_W(OUT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .pdm_stb (pdm_stb),
      .pdm_in  (pdm_in),
      .dec_r   (dec_r),
      .out_if  (bus.master),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int xs [CH][4096];
   int n_stb;
   int r_model;
   int cap_ch[$];
   int cap_data[$];

   typedef struct {
      int p0; int p1; int dec; int dec_late; int e0; int e1;
   } vec_t;
   vec_t vecs [6];

   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         cap_ch.push_back(int'(bus.out_ch));
         cap_data.push_back(int'($signed(bus.out_data)));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int clamp_r(input int d);
      if (d < 2) return 2;
      if (d > RMAX) return RMAX;
      return d;
   endfunction

   // Frame m (1-based) is the input convolved with the CIC impulse response
   // (R ones convolved with itself ORDER times), sampled at the m-th frame end.
   function automatic int ref_out(input int ch, input int m);
      int h [64];
      int t [64];
      int len;
      int acc;
      for (int i = 0; i < 64; i++) h[i] = 0;
      h[0] = 1;
      len = 1;
      for (int s = 0; s < ORDER; s++) begin
         for (int i = 0; i < len + r_model - 1; i++) begin
            t[i] = 0;
            for (int j = 0; j < r_model; j++)
               if (i - j >= 0 && i - j < len) t[i] += h[i-j];
         end
         len += r_model - 1;
         for (int i = 0; i < len; i++) h[i] = t[i];
      end
      acc = 0;
      for (int k = 0; k < len; k++)
         if (m * r_model - 1 - k >= 0) acc += h[k] * xs[ch][m*r_model-1-k];
      return acc >>> (W - OUT_W);
   endfunction

   function automatic logic pat(input int p, input int i);
      case (p)
         0: return 1'b0;
         1: return 1'b1;
         2: return (i % 2) == 0;
         default: return (i % 2) == 1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [CH-1:0] b, input int gap);
      pdm_in  = b;
      pdm_stb = 1'b1;
      for (int c = 0; c < CH; c++) xs[c][n_stb] = b[c] ? 1 : -1;
      n_stb++;
      tick();
      pdm_stb = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic restart(input int dec);
      en    = 1'b0;
      dec_r = 4'(dec);
      tick();
      en = 1'b1;
      tick();
      n_stb   = 0;
      r_model = clamp_r(dec);
      cap_ch.delete();
      cap_data.delete();
   endtask

   task automatic wait_valid(input string name, input int max_cycles);
      int k = 0;
      while (!bus.out_valid && k < max_cycles) begin
         tick();
         k++;
      end
      check(name, int'(bus.out_valid), 1);
   endtask

   initial begin
      int nst, nf;
      vecs[0] = '{1, 0, 8, 8, 512, -512};
      vecs[1] = '{2, 3, 8, 8, 0, 0};
      vecs[2] = '{1, 0, 4, 8, 64, -64};
      vecs[3] = '{1, 1, 1, 1, 8, 8};
      vecs[4] = '{0, 2, 15, 15, -512, 0};
      vecs[5] = '{2, 1, 2, 2, 0, 8};

      rst = 1'b1; en = 1'b1; pdm_stb = 1'b0; pdm_in = '0; dec_r = 4'd8;
      bus.out_ready = 1'b1;
      n_stb = 0; r_model = 8;
      tick(); tick();
      check("reset_valid", int'(bus.out_valid), 0);
      check("reset_data", int'($signed(bus.out_data)), 0);
      check("reset_ch", int'(bus.out_ch), 0);
      check("reset_overrun", int'(overrun), 0);
      rst = 1'b0;
      tick();

      foreach (vecs[v]) begin
         restart(vecs[v].dec);
         dec_r = 4'(vecs[v].dec_late);
         for (int i = 0; i < 5 * r_model; i++)
            strobe({pat(vecs[v].p1, i), pat(vecs[v].p0, i)}, 3);
         repeat (8) tick();
         check($sformatf("vec%0d_count", v), cap_data.size(), 10);
         if (cap_data.size() == 10) begin
            check($sformatf("vec%0d_ch0_idx", v), cap_ch[8], 0);
            check($sformatf("vec%0d_ch1_idx", v), cap_ch[9], 1);
            check($sformatf("vec%0d_ch0_data", v), cap_data[8], vecs[v].e0);
            check($sformatf("vec%0d_ch1_data", v), cap_data[9], vecs[v].e1);
         end
      end

      for (int run = 0; run < 4; run++) begin
         restart(int'($urandom_range(0, 15)));
         nst = r_model * int'($urandom_range(3, 6)) + int'($urandom_range(0, r_model - 1));
         for (int i = 0; i < nst; i++) strobe(2'($urandom), int'($urandom_range(0, 2)));
         repeat (8) tick();
         nf = n_stb / r_model;
         check($sformatf("rand%0d_count", run), cap_data.size(), 2 * nf);
         for (int k = 0; k < cap_data.size() && k < 2 * nf; k++) begin
            check($sformatf("rand%0d_ch[%0d]", run, k), cap_ch[k], k % 2);
            check($sformatf("rand%0d_data[%0d]", run, k), cap_data[k], ref_out(k % 2, k / 2 + 1));
         end
         check($sformatf("rand%0d_overrun", run), int'(overrun), 0);
      end

      restart(8);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 24; i++) strobe(2'b01, 0);
      repeat (3) tick();
      check("ovr_valid", int'(bus.out_valid), 1);
      check("ovr_ch_held", int'(bus.out_ch), 0);
      check("ovr_data_held", int'($signed(bus.out_data)), ref_out(0, 1));
      check("ovr_set", int'(overrun), 1);
      en = 1'b0; tick();
      en = 1'b1; tick();
      check("ovr_cleared", int'(overrun), 0);
      check("ovr_valid_cleared", int'(bus.out_valid), 0);

      restart(8);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) strobe(2'b01, 0);
      wait_valid("rst_first_valid", 6);
      rst = 1'b1;
      tick();
      check("rst_valid_drop", int'(bus.out_valid), 0);
      rst = 1'b0;
      n_stb = 0;
      cap_ch.delete();
      cap_data.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) strobe(2'b01, 1);
      repeat (8) tick();
      check("rst_count", cap_data.size(), 4);
      if (cap_data.size() == 4) begin
         check("rst_f1_ch0", cap_data[0], ref_out(0, 1));
         check("rst_f1_ch1", cap_data[1], ref_out(1, 1));
         check("rst_f2_ch0", cap_data[2], ref_out(0, 2));
      end

      restart(8);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) strobe(2'b01, 0);
      wait_valid("coin_first_valid", 6);
      for (int i = 0; i < 7; i++) strobe(2'b01, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("coin_on_ch1", int'(bus.out_ch), 1);
      bus.out_ready = 1'b1;
      strobe(2'b01, 0);
      check("coin_gap_valid", int'(bus.out_valid), 0);
      tick();
      check("coin_new_valid", int'(bus.out_valid), 1);
      check("coin_new_ch", int'(bus.out_ch), 0);
      check("coin_new_data", int'($signed(bus.out_data)), ref_out(0, 2));
      check("coin_overrun", int'(overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
